// File: rtl/counter_ctrl_pkg.sv
// counter_ctrl_pkg: shared reset constants, synchronizer depth and counter width helper
package counter_ctrl_pkg;
  localparam logic PAUSE_RST = 1'b0;
  localparam logic UPDOWN_RST = 1'b1;
  localparam int SYNC_STAGES = 2;
  function automatic int cnt_width(input int n);
    return $clog2(n);
  endfunction
endpackage

// File: rtl/counter_ctrl_debounce.sv
// btn_debounce: two-flop synchronizer plus stability counter producing a debounced level and press pulse
// ports: CLK, CLR (sync active-high reset), i_raw (async button), o_level (debounced level), o_press (1 cycle, comb, high the cycle before o_level rises)
module btn_debounce
  import counter_ctrl_pkg::*;
#(
  parameter int DB_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic i_raw,
  output logic o_level,
  output logic o_press
);
  localparam int CW = cnt_width(DB_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CW-1:0] r_cnt;
  logic r_db;
  logic w_s2, w_done;
  assign w_s2 = r_sync[SYNC_STAGES-1];
  assign w_done = (w_s2 != r_db) && (r_cnt == CW'(DB_CYCLES - 1));
  // press is combinational so the owner toggles on the same edge the level rises
  assign o_press = w_done && w_s2;
  assign o_level = r_db;
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_db <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], i_raw};
      r_cnt <= (w_s2 == r_db || w_done) ? '0 : r_cnt + 1'b1;
      if (w_done) r_db <= w_s2;
    end
  end
endmodule

// File: rtl/counter_ctrl.sv
// counter_ctrl: debounced pause/direction toggles and programmable count-enable tick for the up/down counter
// ports: CLK, CLR (sync active-high reset), btn_pause, btn_dir (raw buttons), tick_o (1-cycle enable), pause_o (1 = hold), updown_o (1 = up)
// optional: COUNTER_CTRL_STEP_BTN_EN adds btn_step, which forces a single tick while paused
module counter_ctrl
  import counter_ctrl_pkg::*;
#(
  parameter int TICK_DIV = 100000000,
  parameter int DB_CYCLES = 1000000
) (
  input  logic CLK,
  input  logic CLR,
  input  logic btn_pause,
  input  logic btn_dir,
`ifdef COUNTER_CTRL_STEP_BTN_EN
  input  logic btn_step,
`endif
  output logic tick_o,
  output logic pause_o,
  output logic updown_o
);
  localparam int TW = cnt_width(TICK_DIV);
  logic [TW-1:0] r_div;
  logic w_p_press, w_d_press, w_s_tick, w_wrap;
  logic [2:0] w_unused_lvl;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_pause (
    .CLK(CLK), .CLR(CLR), .i_raw(btn_pause), .o_level(w_unused_lvl[0]), .o_press(w_p_press)
  );
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_dir (
    .CLK(CLK), .CLR(CLR), .i_raw(btn_dir), .o_level(w_unused_lvl[1]), .o_press(w_d_press)
  );
`ifdef COUNTER_CTRL_STEP_BTN_EN
  logic w_step_press;
  btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_step (
    .CLK(CLK), .CLR(CLR), .i_raw(btn_step), .o_level(w_unused_lvl[2]), .o_press(w_step_press)
  );
  assign w_s_tick = w_step_press && pause_o;
`else
  assign w_unused_lvl[2] = 1'b0;
  assign w_s_tick = 1'b0;
`endif
  assign w_wrap = r_div == TW'(TICK_DIV - 1);
  // tick and divider use the pre-toggle pause_o, so a toggle and a wrap on one edge see the old mode
  always_ff @(posedge CLK) begin
    if (CLR) begin
      r_div <= '0;
      tick_o <= 1'b0;
      pause_o <= PAUSE_RST;
      updown_o <= UPDOWN_RST;
    end else begin
      pause_o <= pause_o ^ w_p_press;
      updown_o <= updown_o ^ w_d_press;
      if (!pause_o) r_div <= w_wrap ? '0 : r_div + 1'b1;
      tick_o <= (!pause_o && w_wrap) || w_s_tick;
    end
  end
endmodule

// File: tb/tb_counter_ctrl.sv
// tb_counter_ctrl: directed scoreboard bench for counter_ctrl with TICK_DIV=4, DB_CYCLES=3
module tb_counter_ctrl;
  logic clk = 1'b0;
  logic clr = 1'b1;
  logic btn_pause = 1'b0;
  logic btn_dir = 1'b0;
  logic btn_step = 1'b0;
  logic tick_o, pause_o, updown_o;
  typedef struct {
    string tag;
    logic [2:0] v;
  } exp_t;
  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int ph = 0;
  logic pause_e = 1'b0;
  logic dir_e = 1'b1;
  counter_ctrl #(.TICK_DIV(4), .DB_CYCLES(3)) dut (
    .CLK(clk),
    .CLR(clr),
    .btn_pause(btn_pause),
    .btn_dir(btn_dir),
`ifdef COUNTER_CTRL_STEP_BTN_EN
    .btn_step(btn_step),
`endif
    .tick_o(tick_o),
    .pause_o(pause_o),
    .updown_o(updown_o)
  );
  always #5 clk = ~clk;
  task automatic compare_next();
    exp_t it;
    @(posedge clk);
    #1;
    it = q.pop_front();
    checks++;
    assert ({tick_o, pause_o, updown_o} === it.v)
    else begin
      errors++;
      $error("FAIL %s tick/pause/updown got %b want %b", it.tag, {tick_o, pause_o, updown_o}, it.v);
    end
  endtask
  task automatic reset_edges(string tag, int n);
    clr = 1'b1;
    for (int e = 1; e <= n; e++) begin
      q.push_back('{$sformatf("%s@%0d", tag, e), 3'b001});
      compare_next();
    end
    ph = 0;
    pause_e = 1'b0;
    dir_e = 1'b1;
    clr = 1'b0;
  endtask
  // button X is high on edges [x_on, x_on+x_len); tp/td/ts are the edges where the press is expected to land
  task automatic seg(string tag, int n, int p_on, int p_len, int tp, int d_on, int d_len, int td,
                     int s_on, int s_len, int ts);
    for (int e = 1; e <= n; e++) begin
      logic t;
      t = pause_e ? (e == ts) : (ph == 3);
      if (!pause_e) ph = (ph + 1) % 4;
      if (e == tp) pause_e = !pause_e;
      if (e == td) dir_e = !dir_e;
      q.push_back('{$sformatf("%s@%0d", tag, e), {t, pause_e, dir_e}});
    end
    for (int e = 1; e <= n; e++) begin
      btn_pause = (e >= p_on) && (e < p_on + p_len);
      btn_dir = (e >= d_on) && (e < d_on + d_len);
      btn_step = (e >= s_on) && (e < s_on + s_len);
      compare_next();
    end
  endtask
  initial begin
    reset_edges("reset", 2);
    seg("idle", 12, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    seg("dir1", 16, 0, 0, 0, 1, 10, 5, 0, 0, 0);
    seg("dir2", 12, 0, 0, 0, 1, 6, 5, 0, 0, 0);
    seg("glitch", 8, 1, 2, 0, 0, 0, 0, 0, 0, 0);
    seg("pz_on", 14, 2, 6, 6, 0, 0, 0, 0, 0, 0);
    seg("pz_off", 10, 1, 6, 5, 0, 0, 0, 0, 0, 0);
    seg("both", 12, 1, 6, 5, 1, 6, 5, 0, 0, 0);
    seg("mid", 3, 1, 3, 0, 0, 0, 0, 0, 0, 0);
    reset_edges("midclr", 1);
    seg("post", 10, 1, 6, 5, 0, 0, 0, 0, 0, 0);
`ifdef COUNTER_CTRL_STEP_BTN_EN
    seg("st_pz", 12, 1, 6, 5, 0, 0, 0, 0, 0, 0);
    seg("step_p", 12, 0, 0, 0, 0, 0, 0, 1, 6, 5);
    seg("st_run", 12, 1, 6, 5, 0, 0, 0, 0, 0, 0);
    seg("step_r", 12, 0, 0, 0, 0, 0, 0, 1, 6, 5);
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
